// File: rtl/timekeeper_mux.sv
// Time-of-day core: one-second prescaler, BCD hh:mm:ss with carry chain, 12/24-hour
// presentation, set mode, and a six-digit multiplexed seven-segment scanner.
module timekeeper_mux #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned SCAN_DIV      = 50_000,
    parameter bit          MODE_12H      = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_en,
    input  logic       inc_hour,
    input  logic       inc_min,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       pm,
    output logic       sec_pulse,
    output logic [5:0] digit_an,
    output logic [6:0] segments
);

    localparam int unsigned PS_W = $clog2(TICKS_PER_SEC);
    localparam int unsigned SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICKS_PER_SEC - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_DIV - 1);

    logic [PS_W-1:0] ps;
    logic [SC_W-1:0] scan_cnt;
    logic [2:0]      digit_idx;
    logic [7:0]      hour_r;
    logic [7:0]      min_r;
    logic [7:0]      sec_r;
    logic            tick;
    logic [4:0]      hour_bin;
    logic [4:0]      hour_12;
    logic [3:0]      nibble;
    logic            blank;

    // Two-digit BCD increment that wraps to 00 after `last`.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
        if (v == last)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    always_comb begin
        tick = !reset && !set_en && (ps == PS_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ps        <= '0;
            scan_cnt  <= '0;
            digit_idx <= 3'd0;
            hour_r    <= 8'h00;
            min_r     <= 8'h00;
            sec_r     <= 8'h00;
        end else begin
            if (scan_cnt == SC_LAST) begin
                scan_cnt  <= '0;
                digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + SC_W'(1);
            end

            if (set_en) begin
                // Prescaler held at 0 so the first second after release is a full one.
                ps    <= '0;
                sec_r <= 8'h00;
                if (inc_hour)
                    hour_r <= bcd_inc(hour_r, 8'h23);
                if (inc_min)
                    min_r <= bcd_inc(min_r, 8'h59);
            end else if (tick) begin
                ps    <= '0;
                sec_r <= bcd_inc(sec_r, 8'h59);
                if (sec_r == 8'h59) begin
                    min_r <= bcd_inc(min_r, 8'h59);
                    if (min_r == 8'h59)
                        hour_r <= bcd_inc(hour_r, 8'h23);
                end
            end else begin
                ps <= ps + PS_W'(1);
            end
        end
    end

    // Hour presentation and pm flag.
    always_comb begin
        hour_bin = 5'(hour_r[7:4]) * 5'd10 + 5'(hour_r[3:0]);
        if (hour_bin == 5'd0)
            hour_12 = 5'd12;
        else if (hour_bin > 5'd12)
            hour_12 = hour_bin - 5'd12;
        else
            hour_12 = hour_bin;
        pm = (hour_bin >= 5'd12);
        if (!MODE_12H)
            hour_bcd = hour_r;
        else if (hour_12 >= 5'd10)
            hour_bcd = {4'd1, 4'(hour_12 - 5'd10)};
        else
            hour_bcd = {4'd0, 4'(hour_12)};
        min_bcd   = min_r;
        sec_bcd   = sec_r;
        sec_pulse = tick;
    end

    // Digit select and segment decode.
    always_comb begin
        case (digit_idx)
            3'd0:    nibble = sec_r[3:0];
            3'd1:    nibble = sec_r[7:4];
            3'd2:    nibble = min_r[3:0];
            3'd3:    nibble = min_r[7:4];
            3'd4:    nibble = hour_bcd[3:0];
            3'd5:    nibble = hour_bcd[7:4];
            default: nibble = 4'hF;
        endcase
        blank    = MODE_12H && (digit_idx == 3'd5) && (hour_bcd[7:4] == 4'd0);
        segments = blank ? 7'b1111111 : seg_decode(nibble);
        digit_an = ~(6'b000001 << digit_idx);
    end

endmodule

// File: doc/timekeeper_mux.md
# timekeeper_mux

Parametrised time-of-day core for the digital clock: one-second prescaler, BCD hour/minute/second counters with full carry chain, selectable 12/24-hour presentation, a set mode with hour/minute increment inputs, and a built-in six-digit multiplexed seven-segment scanner. It sits between the board clock and the display pins, replacing the separate divider, counter, decoder and display-select logic with one block.

## Interface
- `TICKS_PER_SEC`, 50_000_000, `clk` cycles per second; must be >= 2.
- `SCAN_DIV`, 50_000, `clk` cycles each digit stays lit; must be >= 1.
- `MODE_12H`, 0, 0 selects 24-hour presentation; 1 selects 12-hour presentation with the `pm` flag.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `set_en`  in  1  level; 1 = set mode.
- `inc_hour`  in  1  increments the hour in set mode; sampled every cycle.
- `inc_min`  in  1  increments the minute in set mode; sampled every cycle.
- `hour_bcd`  out  8  presented hour, two BCD digits.
- `min_bcd`  out  8  minute, BCD 00..59.
- `sec_bcd`  out  8  second, BCD 00..59.
- `pm`  out  1  1 when the internal hour is >= 12; valid in both modes.
- `sec_pulse`  out  1  one-cycle strobe on each counted second.
- `digit_an`  out  6  digit enables, one-hot, active-low; bit 0 = seconds ones, bit 5 = hours tens.
- `segments`  out  7  {g,f,e,d,c,b,a}, active-low; 7'b1111111 = blank.

## Operation
- Internal state:
  - prescaler, width $clog2(TICKS_PER_SEC);
  - internal hour 0..23, kept as BCD;
  - minute and second, BCD;
  - scan counter, 0..SCAN_DIV-1;
  - digit index, 0..5.
- Reset values: time 00:00:00, prescaler 0, scan counter 0, digit index 0.
  - `sec_pulse` = 0, `digit_an` = 6'b111110, `segments` = 7'b1000000 (the digit "0").
  - `pm` = 0; `hour_bcd` = 8'h00 in 24-hour mode, 8'h12 in 12-hour mode.
- Run mode (`set_en` = 0):
  - The prescaler counts 0..TICKS_PER_SEC-1 and wraps.
  - In the wrap cycle, `sec_pulse` = 1 and the second advances.
  - 59 -> 00 carries into the minute; minute 59 -> 00 carries into the hour; hour 23 -> 00.
  - A full carry ripples in the same edge: 23:59:59 -> 00:00:00.
- Set mode (`set_en` = 1):
  - The prescaler is held at 0 and `sec_pulse` stays 0.
  - Seconds are forced to 00.
  - `inc_hour` = 1 advances the hour modulo 24 per cycle, with no effect on the minute.
  - `inc_min` = 1 advances the minute modulo 60 per cycle, with no carry into the hour.
  - Both inputs high in the same cycle apply both increments.
  - The increment inputs are ignored when `set_en` = 0.
  - On `set_en` falling, the prescaler restarts from 0, so the next second completes TICKS_PER_SEC cycles later.
- Presentation:
  - 24-hour mode: `hour_bcd` equals the internal hour.
  - 12-hour mode: internal hour 0 -> 12, 1..12 -> 01..12, 13..23 -> 01..11.
- Scan:
  - The scan counter wraps at SCAN_DIV-1; on each wrap the digit index advances 0,1,..,5,0.
  - `digit_an` drives a 0 only on the bit equal to the digit index.
  - Digit order: 0 = seconds ones, 1 = seconds tens, 2 = minutes ones, 3 = minutes tens, 4 = hours ones, 5 = hours tens.
  - `segments` is the active-low decode of the selected nibble.
  - In 12-hour mode the hours-tens digit is blank when it is 0.
  - Nibbles above 9 never occur; if one does, decode it as blank.

## Timing
- Counters, prescaler, scan counter and digit index are registered.
- `sec_pulse`, `digit_an` and `segments` are combinational from registered state and add no latency.
- Time outputs update on the edge that ends the `sec_pulse` cycle.
- With reset released before cycle 0, `sec_pulse` is high in cycle TICKS_PER_SEC-1, and `sec_bcd` = 8'h01 from cycle TICKS_PER_SEC onward.
- Set-mode increments are visible on the outputs in the cycle after they are sampled.
- `digit_an` changes in cycle k*SCAN_DIV, k >= 1; each digit is lit for exactly SCAN_DIV cycles.
- Reset mid-operation overrides every other input in that cycle. All state returns to its reset values on that edge, including set-mode increments and a pending carry.

## Test plan
- Reset and first second (TICKS_PER_SEC=4, SCAN_DIV=2): pulse `reset`, then release it.
  - Required: `digit_an` = 6'b111110, `segments` = 7'b1000000, time 00:00:00.
  - Required: `sec_pulse` high in cycle 3 only; `sec_bcd` = 8'h01 from cycle 4.
- Rollover (TICKS_PER_SEC=4):
  - Stimulus: `set_en`=1, 23 `inc_hour` pulses, 59 `inc_min` pulses, then `set_en`=0; run 240 cycles.
  - Required: reads 23:59:00 before the run, 23:59:59 after 236 cycles, 00:00:00 after 240 cycles.
- Set-mode wrap:
  - Hour 23 + `inc_hour` -> 00 with the minute unchanged.
  - Minute 59 + `inc_min` -> 00 with the hour unchanged.
  - Both increments in one cycle from 05:10 -> 06:11.
  - With `set_en`=0, `inc_hour` held high for 10 cycles -> hour unchanged.
- 12-hour mode (MODE_12H=1):
  - Internal hour 0 -> `hour_bcd` 8'h12, `pm`=0.
  - Internal hour 13 -> 8'h01, `pm`=1; hours-tens digit `segments` = 7'b1111111.
  - Internal hour 12 -> 8'h12, `pm`=1.
- Scan (SCAN_DIV=2, time 12:34:56, 24-hour mode):
  - Required `digit_an` sequence: 111110, 111101, 111011, 110111, 101111, 011111, 111110, each held 2 cycles.
  - Required `segments`: 6 -> 7'b0000010, 5 -> 7'b0010010, 4 -> 7'b0011001, 3 -> 7'b0110000, 2 -> 7'b0100100, 1 -> 7'b1111001.
- Reset mid-run:
  - `reset` at 07:08:09 with the scan at digit 3, and again in a cycle with `inc_min`=1 in set mode.
  - Required: next cycle 00:00:00, `digit_an` = 6'b111110, no increment applied.
